// File: rtl/miss_fill_if.sv
`default_nettype none
// ============================================================================
//  Module   : miss_fill_if
//  Brief    : Bundles the lookup-side miss handshake, the next-level memory
//             request/response port and the data/tag array write port used
//             by miss_fill_ctrl.
//             master = fill controller, slave = surrounding cache/memory.
//  Revision : 1.0  initial release
// ============================================================================
interface miss_fill_if #(
  parameter int N_WAYS     = 2,
  parameter int TAG_BITS   = 21,
  parameter int N_POW      = 4,
  parameter int SET_BITS   = 4,
  parameter int LINE_WORDS = 4,
  parameter int DATA_BITS  = 32
);
  localparam int c_WORD_BITS = $clog2(LINE_WORDS) + 1;

  // lookup stage
  logic                   miss_valid;
  logic                   miss_ready;
  logic [TAG_BITS-1:0]    miss_tag;
  logic [SET_BITS-1:0]    miss_set;
  logic [N_WAYS-1:0]      set_empty;
  // next-level memory
  logic                   mem_req_valid;
  logic                   mem_req_ready;
  logic [TAG_BITS-1:0]    mem_req_tag;
  logic [SET_BITS-1:0]    mem_req_set;
  logic                   mem_rsp_valid;
  logic [DATA_BITS-1:0]   mem_rsp_data;
  // data / tag array write port
  logic                   fill_we;
  logic [N_POW-1:0]       fill_way;
  logic [SET_BITS-1:0]    fill_set;
  logic [c_WORD_BITS-1:0] fill_word;
  logic [DATA_BITS-1:0]   fill_data;
  logic                   tag_we;
  logic [TAG_BITS-1:0]    tag_wdata;
  logic                   tag_wvalid;
  logic                   fill_done;

  modport master (
    input  miss_valid, miss_tag, miss_set, set_empty,
           mem_req_ready, mem_rsp_valid, mem_rsp_data,
    output miss_ready, mem_req_valid, mem_req_tag, mem_req_set,
           fill_we, fill_way, fill_set, fill_word, fill_data,
           tag_we, tag_wdata, tag_wvalid, fill_done
  );

  modport slave (
    output miss_valid, miss_tag, miss_set, set_empty,
           mem_req_ready, mem_rsp_valid, mem_rsp_data,
    input  miss_ready, mem_req_valid, mem_req_tag, mem_req_set,
           fill_we, fill_way, fill_set, fill_word, fill_data,
           tag_we, tag_wdata, tag_wvalid, fill_done
  );
endinterface
`default_nettype wire

// File: rtl/miss_fill_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : miss_fill_ctrl
//  Brief    : Miss handler on the write side of the tag path. Picks a victim
//             way, invalidates it, fetches the line beat by beat into the data
//             array, then commits the new tag as valid. One miss at a time.
//             Build option RR_PER_SET_EN: one round-robin pointer per set
//             instead of a single global pointer.
//  Revision : 1.0  initial release
// ============================================================================
module miss_fill_ctrl #(
  parameter int N_WAYS     = 2,
  parameter int TAG_BITS   = 21,
  parameter int N_POW      = 4,
  parameter int SET_BITS   = 4,
  parameter int LINE_WORDS = 4,
  parameter int DATA_BITS  = 32
) (
  input  wire logic    clk,
  input  wire logic    rst,
  miss_fill_if.master  bus
);
  localparam int                   c_WORD_BITS = $clog2(LINE_WORDS) + 1;
  localparam int                   c_SETS      = 2 ** SET_BITS;
  localparam logic [c_WORD_BITS-1:0] c_LAST_BEAT = c_WORD_BITS'(LINE_WORDS - 1);
  localparam logic [N_POW-1:0]       c_LAST_WAY  = N_POW'(N_WAYS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_INVAL  = 3'd1,
    S_REQ    = 3'd2,
    S_BEAT   = 3'd3,
    S_COMMIT = 3'd4
  } state_t;

  state_t                 r_state;
  state_t                 w_next;
  logic [TAG_BITS-1:0]    r_tag;
  logic [SET_BITS-1:0]    r_set;
  logic [N_POW-1:0]       r_way;
  logic                   r_repl;
  logic [c_WORD_BITS-1:0] r_cnt;
  logic [N_POW-1:0]       w_ptr_sel;     // pointer of the set being looked up
  logic [N_POW-1:0]       w_ptr_commit;  // pointer of the set being filled
  logic [N_POW-1:0]       w_ptr_next;
  logic [N_POW-1:0]       w_victim;
  logic                   w_any_empty;
  logic                   w_accept;
  logic                   w_last_beat;

  assign w_accept    = (r_state == S_IDLE) && bus.miss_valid;
  assign w_last_beat = (r_state == S_BEAT) && bus.mem_rsp_valid && (r_cnt == c_LAST_BEAT);
  assign w_ptr_next  = (w_ptr_commit == c_LAST_WAY) ? '0 : w_ptr_commit + 1'b1;

  // Victim: lowest-index empty way, otherwise the replacement pointer
  always_comb begin
    w_victim    = w_ptr_sel;
    w_any_empty = |bus.set_empty;
    for (int i = N_WAYS - 1; i >= 0; i--) begin
      if (bus.set_empty[i]) w_victim = N_POW'(i);
    end
  end

`ifdef RR_PER_SET_EN
  logic [N_POW-1:0] r_ptr [c_SETS];
  assign w_ptr_sel    = r_ptr[bus.miss_set];
  assign w_ptr_commit = r_ptr[r_set];

  // Per-set round-robin pointers, advanced only by commits that replaced a line
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < c_SETS; s++) r_ptr[s] <= '0;
    end else if (r_state == S_COMMIT && r_repl) begin
      r_ptr[r_set] <= w_ptr_next;
    end
  end
`else
  logic [N_POW-1:0] r_ptr;
  assign w_ptr_sel    = r_ptr;
  assign w_ptr_commit = r_ptr;

  // Single round-robin pointer shared by every set
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (r_state == S_COMMIT && r_repl) begin
      r_ptr <= w_ptr_next;
    end
  end
`endif

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Miss capture and beat counter; reset drops any partial fill
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tag  <= '0;
      r_set  <= '0;
      r_way  <= '0;
      r_repl <= 1'b0;
      r_cnt  <= '0;
    end else begin
      if (w_accept) begin
        r_tag  <= bus.miss_tag;
        r_set  <= bus.miss_set;
        r_way  <= w_victim;
        r_repl <= ~w_any_empty;
      end
      if (r_state == S_BEAT && bus.mem_rsp_valid) begin
        r_cnt <= w_last_beat ? '0 : r_cnt + 1'b1;
      end
    end
  end

  // Next-state and strobes; tag and data strobes live in disjoint states
  always_comb begin
    w_next            = r_state;
    bus.miss_ready    = 1'b0;
    bus.mem_req_valid = 1'b0;
    bus.fill_we       = 1'b0;
    bus.tag_we        = 1'b0;
    bus.tag_wvalid    = 1'b0;
    bus.fill_done     = 1'b0;
    case (r_state)
      S_IDLE: begin
        bus.miss_ready = 1'b1;
        if (bus.miss_valid) w_next = S_INVAL;
      end
      S_INVAL: begin
        bus.tag_we = 1'b1;
        w_next     = S_REQ;
      end
      S_REQ: begin
        bus.mem_req_valid = 1'b1;
        if (bus.mem_req_ready) w_next = S_BEAT;
      end
      S_BEAT: begin
        bus.fill_we = bus.mem_rsp_valid;
        if (w_last_beat) w_next = S_COMMIT;
      end
      S_COMMIT: begin
        bus.tag_we     = 1'b1;
        bus.tag_wvalid = 1'b1;
        bus.fill_done  = 1'b1;
        w_next         = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign bus.mem_req_tag = r_tag;
  assign bus.mem_req_set = r_set;
  assign bus.fill_way    = r_way;
  assign bus.fill_set    = r_set;
  assign bus.fill_word   = r_cnt;
  assign bus.fill_data   = bus.mem_rsp_data;
  assign bus.tag_wdata   = r_tag;

endmodule
`default_nettype wire
